imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of the single-cycle MIPS datapath. Receives a byte stream (valid/ready), packs it into
//  32-bit big-endian instruction words and writes them into the instruction-memory write port.
//  Holds the CPU in reset while loading; releases it once the image is complete.
// PARAMETERS
//  MAX_WORDS  256    largest accepted image, in words (1..65535)
//  BASE_ADDR  32'h0  byte address of the first written word (word aligned)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  reset      in   1   synchronous, active-high reset
//  in_data    in   8   stream byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   loader accepts a byte; transfer = in_valid & in_ready at a clk edge
//  imem_we    out  1   one-cycle instruction-memory write strobe
//  imem_addr  out  32  byte address of the write = BASE_ADDR + 4*word_index
//  imem_data  out  32  instruction word
//  cpu_reset  out  1   drives the datapath reset; high while loading or on error
//  done       out  1   image loaded
//  error      out  1   image rejected
//  word_cnt   out  16  words written since the last reset
// BEHAVIOUR
//  Stream format: LEN_HI, LEN_LO (16-bit word count N), then N x 4 payload bytes, MSB first.
//  Reset values: in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_data=0, cpu_reset=1,
//   done=0, error=0, word_cnt=0, state=LEN_HI, byte counter=0.
//  States: LEN_HI -> LEN_LO -> DATA -> [CHK] -> DONE; any state -> ERR on fault. Each arrow is
//   taken on an accepted byte. DONE and ERR are exited only by reset.
//  in_ready=1 in LEN_HI/LEN_LO/DATA/CHK and 0 in DONE/ERR. No stall inside the loader:
//   one byte per cycle is sustained. Idle cycles (in_valid=0) leave all state unchanged.
//  In LEN_LO: if N > MAX_WORDS, go to ERR. If N == 0, go to DONE (or CHK) with no writes.
//  In DATA: a 2-bit byte counter shifts bytes into the word register. On the 4th byte,
//   imem_we=1 for exactly the next cycle with imem_addr = BASE_ADDR + {word_cnt,2'b00} and the
//   packed data. word_cnt increments at that same edge. imem_addr/imem_data hold after the strobe.
//  Write latency: 1 cycle from acceptance of a word's last byte to imem_we high.
//  The edge that accepts the final byte enters DONE. done=1 from the cycle of the last imem_we.
//   cpu_reset falls one cycle after done rises, so the final write commits before the first fetch.
//  ERR: error=1, cpu_reset stays 1, in_ready=0, no further writes.
//  Address arithmetic is 32-bit and wraps modulo 2^32. The word counter never exceeds N.
//  Reset mid-load: discard the partial word, the counters and the state. Already-written memory
//   words are not cleared. The next stream restarts at BASE_ADDR.
//  Reset asserted in the same cycle as imem_we: the write still occurs (strobe is already
//   registered). All outputs take reset values on the next edge.
// CONFIGURATION
//  IMEM_BOOT_LOADER_CHECKSUM_EN defined: one trailing byte follows the payload and is accepted in
//   state CHK. It must equal the XOR of all payload bytes (0x00 when N=0). Match -> DONE;
//   mismatch -> ERR. Length bytes are excluded from the checksum.
//  Not defined: no CHK state. DATA (or LEN_LO when N=0) goes directly to DONE.
// TESTING
//  1 Reset: hold reset 2 cycles -> in_ready=1, cpu_reset=1, done=0, error=0, imem_we=0, word_cnt=0.
//  2 Stream 00 02 20 08 00 05 20 09 00 07 back-to-back -> writes (0x0,0x20080005),
//    (0x4,0x20090007); each imem_we lasts 1 cycle; done=1 with the 2nd write; cpu_reset=0 one
//    cycle later; word_cnt=2; in_ready=0.
//  3 Same stream with random in_valid gaps of 0-3 cycles -> identical writes and final state.
//  4 Stream 00 00 -> no imem_we; done=1; cpu_reset falls one cycle later. With the checksum macro
//    defined, send 00 00 00 instead.
//  5 Stream 01 01 (N=257 > MAX_WORDS) -> error=1, in_ready=0, cpu_reset stays 1, no writes.
//  6 Reset after 00 01 AA BB -> no write. Then stream 00 01 11 22 33 44 -> one write
//    (0x0,0x11223344). With the checksum macro defined: trailing 0x44 -> done; 0x45 -> error.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a length-prefixed big-endian byte stream into imem writes, holding the CPU in reset until loaded.
// Optional trailing XOR checksum byte when IMEM_BOOT_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
    logic [7:0] csum_q;
`else
    localparam state_t S_FIN = S_DONE;
`endif
    state_t      state_q;
    logic [15:0] len_q;
    logic [1:0]  bcnt_q;
    logic [23:0] word_q;
    logic        imem_we_q;
    logic [31:0] imem_addr_q;
    logic [31:0] imem_data_q;
    logic        cpu_reset_q;
    logic [15:0] word_cnt_q;
    logic        accept;
    logic [15:0] len_d;
    logic [31:0] word_d;
    logic        last_word;
    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept    = in_valid && in_ready;
    assign len_d     = {len_q[7:0], in_data};
    assign word_d    = {word_q, in_data};
    assign last_word = (word_cnt_q + 16'd1) == len_q;
    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_data = imem_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = state_q == S_DONE;
    assign error     = state_q == S_ERR;
    assign word_cnt  = word_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= BASE_ADDR;
            imem_data_q <= '0;
            cpu_reset_q <= 1'b1;
            word_cnt_q  <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            imem_we_q   <= 1'b0;
            // Released one cycle after DONE so the final write lands before the first fetch.
            cpu_reset_q <= state_q != S_DONE;
            if (accept) begin
                case (state_q)
                    S_LEN_HI: begin
                        len_q   <= {8'h00, in_data};
                        state_q <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q   <= len_d;
                        state_q <= (32'(len_d) > MAX_WORDS) ? S_ERR : (len_d == 16'd0) ? S_FIN : S_DATA;
                    end
                    S_DATA: begin
                        word_q <= word_d[23:0];
                        bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            imem_we_q   <= 1'b1;
                            imem_addr_q <= BASE_ADDR + {14'b0, word_cnt_q, 2'b00};
                            imem_data_q <= word_d;
                            word_cnt_q  <= word_cnt_q + 16'd1;
                            if (last_word)
                                state_q <= S_FIN;
                        end
                    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    S_CHK: state_q <= (in_data == csum_q) ? S_DONE : S_ERR;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
